// File: rtl/ssd1331_pkg.sv
// Shared SSD1331 command definitions and argument-count table for the SPI sink.
package ssd1331_pkg;

  localparam int DEF_WIDTH  = 96;
  localparam int DEF_HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL     = 8'h15;
  localparam logic [7:0] CMD_SET_ROW     = 8'h75;
  localparam logic [7:0] CMD_DRAW_LINE   = 8'h21;
  localparam logic [7:0] CMD_DRAW_RECT   = 8'h22;
  localparam logic [7:0] CMD_COPY        = 8'h23;
  localparam logic [7:0] CMD_DIM_WIN     = 8'h24;
  localparam logic [7:0] CMD_CLEAR       = 8'h25;
  localparam logic [7:0] CMD_FILL        = 8'h26;
  localparam logic [7:0] CMD_SCROLL      = 8'h27;
  localparam logic [7:0] CMD_CONTRAST_A  = 8'h81;
  localparam logic [7:0] CMD_CONTRAST_B  = 8'h82;
  localparam logic [7:0] CMD_CONTRAST_C  = 8'h83;
  localparam logic [7:0] CMD_MASTER_CUR  = 8'h87;
  localparam logic [7:0] CMD_PRECHG_A    = 8'h8A;
  localparam logic [7:0] CMD_PRECHG_B    = 8'h8B;
  localparam logic [7:0] CMD_PRECHG_C    = 8'h8C;
  localparam logic [7:0] CMD_REMAP       = 8'hA0;
  localparam logic [7:0] CMD_START_LINE  = 8'hA1;
  localparam logic [7:0] CMD_OFFSET      = 8'hA2;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DIM_MODE    = 8'hAB;
  localparam logic [7:0] CMD_MASTER_CFG  = 8'hAD;
  localparam logic [7:0] CMD_POWER_SAVE  = 8'hB0;
  localparam logic [7:0] CMD_PHASE       = 8'hB1;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hB3;
  localparam logic [7:0] CMD_GRAY_TABLE  = 8'hB8;
  localparam logic [7:0] CMD_PRECHG_LVL  = 8'hBB;
  localparam logic [7:0] CMD_VCOMH       = 8'hBE;

  typedef enum logic {ST_IDLE = 1'b0, ST_ARGS = 1'b1} cmd_state_e;

  // Anything not listed (display on/off, modes, unknown) takes no arguments.
  function automatic logic [5:0] arg_count(input logic [7:0] op);
    case (op)
      CMD_SET_COL, CMD_SET_ROW:                  arg_count = 6'd2;
      CMD_DRAW_LINE:                             arg_count = 6'd7;
      CMD_DRAW_RECT:                             arg_count = 6'd10;
      CMD_COPY:                                  arg_count = 6'd6;
      CMD_DIM_WIN, CMD_CLEAR:                    arg_count = 6'd4;
      CMD_SCROLL, CMD_DIM_MODE:                  arg_count = 6'd5;
      CMD_FILL, CMD_CONTRAST_A, CMD_CONTRAST_B,
      CMD_CONTRAST_C, CMD_MASTER_CUR,
      CMD_PRECHG_A, CMD_PRECHG_B, CMD_PRECHG_C,
      CMD_REMAP, CMD_START_LINE, CMD_OFFSET,
      CMD_MUX_RATIO, CMD_MASTER_CFG,
      CMD_POWER_SAVE, CMD_PHASE, CMD_CLK_DIV,
      CMD_PRECHG_LVL, CMD_VCOMH:                 arg_count = 6'd1;
      CMD_GRAY_TABLE:                            arg_count = 6'd32;
      default:                                   arg_count = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronizers, sck edge detect,
// MSB-first shift register, byte pulse and partial-byte abort pulse.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       cs_abort
);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, dc_sync_q, dc_sync_d;
  logic       sck_prev_q, sck_prev_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d, dc_lat_q, dc_lat_d;
  logic       byte_valid_q, byte_valid_d, byte_is_data_q, byte_is_data_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       abort_q, abort_d;
  logic       cs_s, sck_s, mosi_s, dc_s, sck_rise;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
    sck_prev_d  = sck_s;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    dc_lat_d    = dc_lat_q;
    abort_d     = 1'b0;
    if (cs_s) begin
      // Clearing the count makes the abort a single-cycle pulse.
      cnt_d   = 3'd0;
      abort_d = (cnt_q != 3'd0);
    end else if (sck_rise) begin
      shift_d = {shift_q[6:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done_d   = 1'b1;
        dc_lat_d = dc_s;
      end
    end
    byte_valid_d   = done_q;
    byte_data_d    = done_q ? shift_q  : byte_data_q;
    byte_is_data_d = done_q ? dc_lat_q : byte_is_data_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_sync_q      <= '1;
      sck_sync_q     <= '0;
      mosi_sync_q    <= '0;
      dc_sync_q      <= '0;
      sck_prev_q     <= 1'b0;
      shift_q        <= 8'd0;
      cnt_q          <= 3'd0;
      done_q         <= 1'b0;
      dc_lat_q       <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'd0;
      byte_is_data_q <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      cs_sync_q      <= cs_sync_d;
      sck_sync_q     <= sck_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      dc_sync_q      <= dc_sync_d;
      sck_prev_q     <= sck_prev_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      dc_lat_q       <= dc_lat_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      abort_q        <= abort_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign cs_abort     = abort_q;

endmodule

// File: rtl/ssd1331_spi_sink.sv
// SSD1331 display-side SPI sink: command decode, column/row windowing and
// RGB565 pixel assembly with an auto-advancing cursor.
module ssd1331_spi_sink
  import ssd1331_pkg::*;
#(
  parameter int  WIDTH       = DEF_WIDTH,
  parameter int  HEIGHT      = DEF_HEIGHT,
  parameter int  SYNC_STAGES = 2,
  localparam int X_W         = $clog2(WIDTH),
  localparam int Y_W         = $clog2(HEIGHT)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           spi_cs,
  input  logic           spi_sck,
  input  logic           spi_mosi,
  input  logic           spi_dc,
  output logic           byte_valid,
  output logic [7:0]     byte_data,
  output logic           byte_is_data,
  output logic           cmd_valid,
  output logic [7:0]     cmd_opcode,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [15:0]    pix_rgb,
  output logic           frame_done,
  output logic           cs_abort
);

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .resetn       (resetn),
    .spi_cs       (spi_cs),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_dc       (spi_dc),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .cs_abort     (cs_abort)
  );

  function automatic logic [X_W-1:0] clamp_x(input logic [7:0] v);
    if (int'(v) > WIDTH - 1) return X_W'(WIDTH - 1);
    return X_W'(v);
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [7:0] v);
    if (int'(v) > HEIGHT - 1) return Y_W'(HEIGHT - 1);
    return Y_W'(v);
  endfunction

  cmd_state_e     state_q, state_d;
  logic [5:0]     rem_q, rem_d;
  logic [7:0]     prev_arg_q, prev_arg_d;
  logic [X_W-1:0] col_start_q, col_start_d, col_end_q, col_end_d, cur_x_q, cur_x_d;
  logic [Y_W-1:0] row_start_q, row_start_d, row_end_q, row_end_d, cur_y_q, cur_y_d;
  logic           phase_q, phase_d;
  logic [7:0]     hi_q, hi_d;
  logic           cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic           frame_done_q, frame_done_d;
  logic [7:0]     cmd_opcode_q, cmd_opcode_d;
  logic [X_W-1:0] pix_x_q, pix_x_d, ax_s, ax_e;
  logic [Y_W-1:0] pix_y_q, pix_y_d, ay_s, ay_e;
  logic [15:0]    pix_rgb_q, pix_rgb_d;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    prev_arg_d   = prev_arg_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    cmd_valid_d  = 1'b0;
    cmd_opcode_d = cmd_opcode_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    // Window arguments: the previous argument byte is the start, this one the end.
    ax_s = clamp_x(prev_arg_q);
    ax_e = clamp_x(byte_data);
    ay_s = clamp_y(prev_arg_q);
    ay_e = clamp_y(byte_data);
    if (ax_s > ax_e) ax_e = ax_s;
    if (ay_s > ay_e) ay_e = ay_s;

    if (byte_valid) begin
      if (!byte_is_data) begin
        phase_d = 1'b0;
        if (state_q == ST_IDLE) begin
          cmd_valid_d  = 1'b1;
          cmd_opcode_d = byte_data;
          rem_d        = arg_count(byte_data);
          if (arg_count(byte_data) != 6'd0) state_d = ST_ARGS;
        end else begin
          prev_arg_d = byte_data;
          rem_d      = rem_q - 6'd1;
          if (rem_q == 6'd1) begin
            state_d = ST_IDLE;
            if (cmd_opcode_q == CMD_SET_COL) begin
              col_start_d = ax_s;
              col_end_d   = ax_e;
              cur_x_d     = ax_s;
            end else if (cmd_opcode_q == CMD_SET_ROW) begin
              row_start_d = ay_s;
              row_end_d   = ay_e;
              cur_y_d     = ay_s;
            end
          end
        end
      end else if (!phase_q) begin
        hi_d    = byte_data;
        phase_d = 1'b1;
      end else begin
        phase_d     = 1'b0;
        pix_valid_d = 1'b1;
        pix_x_d     = cur_x_q;
        pix_y_d     = cur_y_q;
        pix_rgb_d   = {hi_q, byte_data};
        if (cur_x_q != col_end_q) begin
          cur_x_d = cur_x_q + 1'b1;
        end else begin
          cur_x_d = col_start_q;
          if (cur_y_q != row_end_q) begin
            cur_y_d = cur_y_q + 1'b1;
          end else begin
            cur_y_d      = row_start_q;
            frame_done_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      rem_q        <= 6'd0;
      prev_arg_q   <= 8'd0;
      col_start_q  <= '0;
      col_end_q    <= X_W'(WIDTH - 1);
      row_start_q  <= '0;
      row_end_q    <= Y_W'(HEIGHT - 1);
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      phase_q      <= 1'b0;
      hi_q         <= 8'd0;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= 8'd0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      prev_arg_q   <= prev_arg_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_opcode_q <= cmd_opcode_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = cmd_opcode_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd1331_spi_sink.sv
// Scoreboard bench for ssd1331_spi_sink: SPI byte stimulus feeds a reference
// model that queues expected bytes, commands and pixels; a monitor compares.
module tb_ssd1331_spi_sink;
  localparam int W  = 20;
  localparam int H  = 10;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0, resetn = 1'b0;
  logic          spi_cs = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0;
  logic          byte_valid, byte_is_data, cmd_valid, pix_valid, frame_done, cs_abort;
  logic [7:0]    byte_data, cmd_opcode;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_rgb;

  ssd1331_spi_sink #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .spi_cs(spi_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_is_data(byte_is_data), .cmd_valid(cmd_valid),
    .cmd_opcode(cmd_opcode), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .cs_abort(cs_abort)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int rgb; int fd;} pix_t;

  int   checks = 0, failures = 0;
  int   exp_bytes[$];
  int   exp_cmds[$];
  pix_t exp_pix[$];
  int   obs_bytes = 0, obs_cmds = 0, obs_pix = 0, obs_fd = 0, obs_abort = 0, exp_abort = 0;
  int   half = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=nothing_pending", name, act);
  endtask

  // ---------------- reference model ----------------
  int m_rem, m_op, m_cs, m_ce, m_rs, m_re, m_cx, m_cy, m_hi;
  bit m_ph;
  int m_args[$];

  function automatic int tb_args(input int op);
    case (op)
      'h15, 'h75: return 2;
      'h21:       return 7;
      'h22:       return 10;
      'h25:       return 4;
      'hB8:       return 32;
      'hA0, 'h81: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_rem = 0; m_op = 0; m_args.delete();
    m_cs = 0; m_ce = W - 1; m_rs = 0; m_re = H - 1;
    m_cx = 0; m_cy = 0; m_ph = 0; m_hi = 0;
  endfunction

  function automatic void model_byte(input bit dc, input int b);
    pix_t p;
    int   s, e;
    exp_bytes.push_back(dc * 256 + b);
    if (!dc) begin
      m_ph = 0;
      if (m_rem == 0) begin
        exp_cmds.push_back(b);
        m_op = b; m_rem = tb_args(b); m_args.delete();
      end else begin
        m_args.push_back(b);
        m_rem--;
        if (m_rem == 0 && (m_op == 'h15 || m_op == 'h75)) begin
          s = min2(m_args[0], (m_op == 'h15) ? W - 1 : H - 1);
          e = min2(m_args[1], (m_op == 'h15) ? W - 1 : H - 1);
          if (s > e) e = s;
          if (m_op == 'h15) begin m_cs = s; m_ce = e; m_cx = s; end
          else              begin m_rs = s; m_re = e; m_cy = s; end
        end
      end
    end else if (!m_ph) begin
      m_hi = b; m_ph = 1;
    end else begin
      p.x = m_cx; p.y = m_cy; p.rgb = m_hi * 256 + b; p.fd = 0; m_ph = 0;
      if (m_cx != m_ce) m_cx++;
      else begin
        m_cx = m_cs;
        if (m_cy != m_re) m_cy++;
        else begin m_cy = m_rs; p.fd = 1; end
      end
      exp_pix.push_back(p);
    end
  endfunction

  // ---------------- monitor ----------------
  bit   prev_bv = 0, prev_cv = 0, prev_pv = 0;
  pix_t mp;
  always @(negedge clk) begin
    if (resetn) begin
      if (byte_valid) begin
        obs_bytes++;
        chk("byte_pulse_width", {31'd0, prev_bv}, 0);
        if (exp_bytes.size() == 0) unexpected("byte_unexpected", {23'd0, byte_is_data, byte_data});
        else chk("byte", {23'd0, byte_is_data, byte_data}, exp_bytes.pop_front());
      end
      if (cmd_valid) begin
        obs_cmds++;
        chk("cmd_pulse_width", {31'd0, prev_cv}, 0);
        if (exp_cmds.size() == 0) unexpected("cmd_unexpected", {24'd0, cmd_opcode});
        else chk("cmd_opcode", {24'd0, cmd_opcode}, exp_cmds.pop_front());
      end
      if (pix_valid) begin
        obs_pix++;
        if (frame_done) obs_fd++;
        chk("pix_pulse_width", {31'd0, prev_pv}, 0);
        if (exp_pix.size() == 0) unexpected("pix_unexpected", {pix_x, pix_y, pix_rgb});
        else begin
          mp = exp_pix.pop_front();
          chk("pix_x", 32'(pix_x), mp.x);
          chk("pix_y", 32'(pix_y), mp.y);
          chk("pix_rgb", {16'd0, pix_rgb}, mp.rgb);
          chk("frame_done", {31'd0, frame_done}, mp.fd);
        end
      end else if (frame_done) begin
        unexpected("frame_done_without_pix", {31'd0, frame_done});
      end
      if (cs_abort) obs_abort++;
      prev_bv = byte_valid; prev_cv = cmd_valid; prev_pv = pix_valid;
    end else begin
      prev_bv = 0; prev_cv = 0; prev_pv = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    model_byte(dc, int'(b));
    spi_cs = 1'b0; spi_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      wait_clk(half); spi_sck = 1'b1;
      wait_clk(half); spi_sck = 1'b0;
    end
  endtask

  task automatic send_pixel(input logic [15:0] rgb);
    send_byte(1'b1, rgb[15:8]);
    send_byte(1'b1, rgb[7:0]);
  endtask

  task automatic send_partial(input int nbits);
    exp_abort++;
    spi_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = 1'($urandom);
      wait_clk(half); spi_sck = 1'b1;
      wait_clk(half); spi_sck = 1'b0;
    end
    wait_clk(2); spi_cs = 1'b1;
    wait_clk(4); spi_cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic drain();
    wait_clk(12);
  endtask

  task automatic check_outputs_zero();
    chk("rst_byte_valid", {31'd0, byte_valid}, 0);
    chk("rst_byte_data", {24'd0, byte_data}, 0);
    chk("rst_byte_is_data", {31'd0, byte_is_data}, 0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("rst_cmd_opcode", {24'd0, cmd_opcode}, 0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    chk("rst_pix_y", 32'(pix_y), 0);
    chk("rst_pix_rgb", {16'd0, pix_rgb}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_cs_abort", {31'd0, cs_abort}, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0;
    wait_clk(3);
    check_outputs_zero();
    model_reset();
    resetn = 1'b1;
    wait_clk(4);
  endtask

  logic [7:0] ops [12] = '{8'h15, 8'h75, 8'h21, 8'h22, 8'h25, 8'hB8,
                           8'hAE, 8'hAF, 8'hA0, 8'h81, 8'hA4, 8'h5A};

  initial begin
    int pb, fb, cb, bb, ab, r;
    model_reset();
    do_reset();

    // Full window frame
    send_byte(0, 8'h15); send_byte(0, 8'h00); send_byte(0, 8'h5F);
    send_byte(0, 8'h75); send_byte(0, 8'h00); send_byte(0, 8'h3F);
    drain();
    pb = obs_pix; fb = obs_fd;
    for (int i = 0; i < W * H; i++) send_pixel(16'($urandom));
    drain();
    chk("frame_pix_count", obs_pix - pb, W * H);
    chk("frame_done_count", obs_fd - fb, 1);
    send_pixel(16'h0BAD);

    // Small window wraps and restarts
    send_byte(0, 8'h15); send_byte(0, 8'd2); send_byte(0, 8'd4);
    send_byte(0, 8'h75); send_byte(0, 8'd1); send_byte(0, 8'd2);
    drain();
    pb = obs_pix; fb = obs_fd;
    for (int i = 0; i < 7; i++) send_pixel(16'hF800);
    drain();
    chk("win_pix_count", obs_pix - pb, 7);
    chk("win_frame_done_count", obs_fd - fb, 1);

    // Clamp and end := start
    send_byte(0, 8'h15); send_byte(0, 8'hFF); send_byte(0, 8'h10);
    send_pixel(16'h1111); send_pixel(16'h2222);

    // Gray table arguments are consumed, window untouched
    drain();
    cb = obs_cmds; pb = obs_pix;
    send_byte(0, 8'hB8);
    for (int i = 0; i < 32; i++) send_byte(0, 8'($urandom));
    send_byte(0, 8'hAF);
    drain();
    chk("b8_cmd_count", obs_cmds - cb, 2);
    chk("b8_pix_count", obs_pix - pb, 0);
    send_pixel(16'h3333);

    // Command resets pixel phase
    send_byte(1, 8'hAA); send_byte(0, 8'hAE); send_byte(1, 8'h12); send_byte(1, 8'h34);

    // Partial byte abort, then a clean byte
    drain();
    bb = obs_bytes; ab = obs_abort;
    send_partial(5);
    drain();
    chk("abort_count", obs_abort - ab, 1);
    chk("abort_no_byte", obs_bytes - bb, 0);
    send_byte(0, 8'h3C);
    drain();
    chk("after_abort_bytes", obs_bytes - bb, 1);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      half = $urandom_range(2, 3);
      r = $urandom_range(0, 99);
      if (r < 5) send_partial($urandom_range(1, 7));
      else if (r < 45) begin
        if (m_rem == 0) send_byte(0, ops[$urandom_range(0, 11)]);
        else send_byte(0, 8'($urandom));
      end else send_byte(1, 8'($urandom));
    end
    half = 2;
    while (m_rem != 0) send_byte(0, 8'h00);

    // Reset in the middle of a column command
    send_byte(0, 8'h15); send_byte(0, 8'h02);
    drain();
    chk("pre_reset_bytes_pending", exp_bytes.size(), 0);
    chk("pre_reset_pix_pending", exp_pix.size(), 0);
    do_reset();
    send_pixel(16'hABCD); send_pixel(16'h5678);
    drain();

    chk("final_bytes_pending", exp_bytes.size(), 0);
    chk("final_cmds_pending", exp_cmds.size(), 0);
    chk("final_pix_pending", exp_pix.size(), 0);
    chk("final_abort_count", obs_abort, exp_abort);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
